// File: rtl/sb_prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// sb_prefetch_ctrl
//
// Sits between a cache line-miss handler and a stream_buffer. It accepts one
// line miss at a time. If the stream_buffer already holds or is fetching the
// missed label, the controller waits for that line. Otherwise it invalidates
// the stream_buffer and re-targets it at the missed label.
//
// Once the full line is present, the controller returns it upstream with a
// one-cycle miss_ack. It then spends one PREFETCH cycle. When the optional
// next-line prefetch is enabled, that cycle points the stream_buffer at the
// following sequential label.
//
// Optional feature macro: SB_NEXT_LINE_PREFETCH_EN
//   defined   : PREFETCH issues sb_label_i = label+1 with sb_label_i_rdy.
//   undefined : PREFETCH is a quiet cycle; the stream_buffer keeps its line.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   miss_req        upstream miss request, held until miss_ack
//   miss_label      label (tag+index) of the missed line
//   miss_ack        one-cycle pulse, line_o valid in the same cycle
//   line_o          refilled line data
//   sb_label_i      label driven to the stream_buffer
//   sb_label_i_rdy  one-cycle pulse: stream_buffer starts fetching sb_label_i
//   sb_inv          one-cycle pulse: invalidate the stream_buffer
//   sb_label_o      label currently held by the stream_buffer
//   sb_label_o_vld  sb_label_o valid
//   sb_data         stream_buffer line data
//   sb_data_vld     per-word valid bits of sb_data
//   hit_cnt         saturating count of misses served without re-target
//   miss_cnt        saturating count of misses that forced a re-target
// ---------------------------------------------------------------------------
module sb_prefetch_ctrl #(
  parameter  int LINE_WIDTH  = 256,
  parameter  int DATA_WIDTH  = 32,
  parameter  int PHYS_WIDTH  = 32,
  localparam int LABEL_WIDTH = PHYS_WIDTH - $clog2(LINE_WIDTH / 8),
  localparam int NWORD       = LINE_WIDTH / DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [LABEL_WIDTH-1:0] miss_label,
  output logic                   miss_ack,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic [LABEL_WIDTH-1:0] sb_label_i,
  output logic                   sb_label_i_rdy,
  output logic                   sb_inv,
  input  logic [LABEL_WIDTH-1:0] sb_label_o,
  input  logic                   sb_label_o_vld,
  input  logic [LINE_WIDTH-1:0]  sb_data,
  input  logic [NWORD-1:0]       sb_data_vld,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    INV,
    ISSUE,
    WAIT_LINE,
    PREFETCH
  } state_t;

  state_t                 state;
  logic [LABEL_WIDTH-1:0] label_q;
  logic                   idle_hit;
  logic                   line_ready;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // A request hits when the stream_buffer already holds or is fetching
  // the label. Data completeness is not needed for the hit decision.
  assign idle_hit   = sb_label_o_vld && (sb_label_o == miss_label);

  // A label mismatch here simply keeps the FSM waiting.
  assign line_ready = sb_label_o_vld && (sb_label_o == label_q) && (&sb_data_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      label_q        <= '0;
      miss_ack       <= 1'b0;
      line_o         <= '0;
      sb_label_i     <= '0;
      sb_label_i_rdy <= 1'b0;
      sb_inv         <= 1'b0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle.
      miss_ack       <= 1'b0;
      sb_inv         <= 1'b0;
      sb_label_i_rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (miss_req) begin
            label_q <= miss_label;
            if (idle_hit) begin
              hit_cnt <= sat_inc(hit_cnt);
              state   <= WAIT_LINE;
            end else begin
              miss_cnt <= sat_inc(miss_cnt);
              if (sb_label_o_vld) begin
                // A stale line must be dropped before re-targeting.
                sb_inv <= 1'b1;
                state  <= INV;
              end else begin
                // The stream_buffer is empty, so the label can be
                // issued straight away.
                sb_label_i     <= miss_label;
                sb_label_i_rdy <= 1'b1;
                state          <= ISSUE;
              end
            end
          end
        end

        INV: begin
          // sb_inv is high during this cycle. The label is issued in the
          // next cycle, so sb_inv and sb_label_i_rdy never overlap.
          sb_label_i     <= label_q;
          sb_label_i_rdy <= 1'b1;
          state          <= ISSUE;
        end

        ISSUE: begin
          state <= WAIT_LINE;
        end

        WAIT_LINE: begin
          if (line_ready) begin
            line_o   <= sb_data;
            miss_ack <= 1'b1;
            state    <= PREFETCH;
          end
        end

        PREFETCH: begin
`ifdef SB_NEXT_LINE_PREFETCH_EN
          // The stream_buffer accepts a new label after delivering a full
          // line, so no invalidate is needed. The label wraps modulo
          // 2^LABEL_WIDTH.
          sb_label_i     <= label_q + LABEL_WIDTH'(1);
          sb_label_i_rdy <= 1'b1;
`endif
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_prefetch_ctrl.sv
module tb_sb_prefetch_ctrl;

  localparam int LW  = 27;
  localparam int FILL = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           miss_req = 1'b0;
  logic [LW-1:0]  miss_label = '0;
  logic           miss_ack;
  logic [255:0]   line_o;
  logic [LW-1:0]  sb_label_i;
  logic           sb_label_i_rdy;
  logic           sb_inv;
  logic [LW-1:0]  sb_label_o;
  logic           sb_label_o_vld;
  logic [255:0]   sb_data;
  logic [7:0]     sb_data_vld;
  logic [31:0]    hit_cnt;
  logic [31:0]    miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sb_prefetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_req       (miss_req),
    .miss_label     (miss_label),
    .miss_ack       (miss_ack),
    .line_o         (line_o),
    .sb_label_i     (sb_label_i),
    .sb_label_i_rdy (sb_label_i_rdy),
    .sb_inv         (sb_inv),
    .sb_label_o     (sb_label_o),
    .sb_label_o_vld (sb_label_o_vld),
    .sb_data        (sb_data),
    .sb_data_vld    (sb_data_vld),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  // Recognisable per-label line content from the stream_buffer model.
  function automatic logic [255:0] line_of(input logic [LW-1:0] l);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = {5'd0, l} ^ (32'(i + 1) * 32'h0101_0101);
    return r;
  endfunction

  // Behavioural stream_buffer: fills a whole line FILL cycles after a label
  // is issued. The bench can preload a complete line through pre_go.
  logic          pre_go = 1'b0;
  logic [LW-1:0] pre_lbl = '0;
  logic [LW-1:0] m_lbl;
  logic          m_vld;
  logic [7:0]    m_dv;
  int            m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lbl <= '0; m_vld <= 1'b0; m_dv <= '0; m_cnt <= 0;
    end else if (pre_go) begin
      m_lbl <= pre_lbl; m_vld <= 1'b1; m_dv <= 8'hFF; m_cnt <= 0;
    end else if (sb_inv) begin
      m_vld <= 1'b0; m_dv <= '0; m_cnt <= 0;
    end else if (sb_label_i_rdy) begin
      m_lbl <= sb_label_i; m_vld <= 1'b1; m_dv <= '0; m_cnt <= FILL;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt <= 0; m_dv <= 8'hFF;
    end
  end

  assign sb_label_o     = m_lbl;
  assign sb_label_o_vld = m_vld;
  assign sb_data_vld    = m_dv;
  assign sb_data        = line_of(m_lbl);

  typedef struct {
    logic          pre;
    logic [LW-1:0] pre_lbl;
    logic [LW-1:0] lbl;
    logic          hit;
    logic          inv;
    logic [31:0]   hc;
    logic [31:0]   mc;
    int            lat;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_miss(input string tag, input vec_t v);
    int            cyc;
    logic          got, inv_seen, iss_seen, both;
    logic [LW-1:0] iss_lbl;
    @(negedge clk);
    if (v.pre) begin
      pre_lbl = v.pre_lbl;
      pre_go  = 1'b1;
    end
    @(negedge clk);
    pre_go = 1'b0;
    @(negedge clk);
    miss_label = v.lbl;
    miss_req   = 1'b1;
    cyc = 0; got = 1'b0; inv_seen = 1'b0; iss_seen = 1'b0; both = 1'b0; iss_lbl = '0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (sb_inv) inv_seen = 1'b1;
      if (sb_label_i_rdy) begin
        iss_seen = 1'b1;
        iss_lbl  = sb_label_i;
      end
      if (sb_inv && sb_label_i_rdy) both = 1'b1;
      if (miss_ack) got = 1'b1;
    end
    miss_req = 1'b0;
    chk({tag, ".ack"},      256'(got), 256'(1'b1));
    chk({tag, ".line"},     line_o, line_of(v.lbl));
    chk({tag, ".hit_cnt"},  256'(hit_cnt), 256'(v.hc));
    chk({tag, ".miss_cnt"}, 256'(miss_cnt), 256'(v.mc));
    chk({tag, ".inv"},      256'(inv_seen), 256'(v.inv));
    chk({tag, ".issue"},    256'(iss_seen), 256'(!v.hit));
    chk({tag, ".overlap"},  256'(both), 256'(1'b0));
    if (!v.hit) chk({tag, ".issue_lbl"}, 256'(iss_lbl), 256'(v.lbl));
    if (v.lat != 0) chk({tag, ".latency"}, 256'(cyc), 256'(v.lat));
    @(negedge clk);
    chk({tag, ".ack_pulse"}, 256'(miss_ack), 256'(1'b0));
`ifdef SB_NEXT_LINE_PREFETCH_EN
    chk({tag, ".pf_rdy"}, 256'(sb_label_i_rdy), 256'(1'b1));
    chk({tag, ".pf_lbl"}, 256'(sb_label_i), 256'(v.lbl + 27'd1));
`else
    chk({tag, ".pf_rdy"}, 256'(sb_label_i_rdy), 256'(1'b0));
`endif
    chk({tag, ".pf_inv"}, 256'(sb_inv), 256'(1'b0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".miss_ack"}, 256'(miss_ack), '0);
    chk({tag, ".line_o"},   line_o, '0);
    chk({tag, ".label_i"},  256'(sb_label_i), '0);
    chk({tag, ".rdy"},      256'(sb_label_i_rdy), '0);
    chk({tag, ".inv"},      256'(sb_inv), '0);
    chk({tag, ".hit_cnt"},  256'(hit_cnt), '0);
    chk({tag, ".miss_cnt"}, 256'(miss_cnt), '0);
  endtask

  vec_t vecs[6];
  vec_t v;
  logic ack_seen;

  initial begin
    // With next-line prefetch, the repeat miss goes to label+1, which the
    // stream_buffer is still fetching, so its latency is not fixed.
`ifdef SB_NEXT_LINE_PREFETCH_EN
    vecs[0] = '{1'b0, 27'h0,  27'h10,       1'b0, 1'b0, 32'd0, 32'd1, 0};
    vecs[1] = '{1'b0, 27'h0,  27'h11,       1'b1, 1'b0, 32'd1, 32'd1, 0};
    vecs[2] = '{1'b1, 27'h20, 27'h30,       1'b0, 1'b1, 32'd1, 32'd2, 0};
    vecs[3] = '{1'b0, 27'h0,  27'h31,       1'b1, 1'b0, 32'd2, 32'd2, 0};
    vecs[4] = '{1'b1, 27'h5,  27'h7FF_FFFF, 1'b0, 1'b1, 32'd2, 32'd3, 0};
    vecs[5] = '{1'b0, 27'h0,  27'h0,        1'b1, 1'b0, 32'd3, 32'd3, 0};
`else
    vecs[0] = '{1'b0, 27'h0,  27'h10,       1'b0, 1'b0, 32'd0, 32'd1, 0};
    vecs[1] = '{1'b0, 27'h0,  27'h10,       1'b1, 1'b0, 32'd1, 32'd1, 2};
    vecs[2] = '{1'b1, 27'h20, 27'h30,       1'b0, 1'b1, 32'd1, 32'd2, 0};
    vecs[3] = '{1'b0, 27'h0,  27'h30,       1'b1, 1'b0, 32'd2, 32'd2, 2};
    vecs[4] = '{1'b1, 27'h5,  27'h7FF_FFFF, 1'b0, 1'b1, 32'd2, 32'd3, 0};
    vecs[5] = '{1'b0, 27'h0,  27'h0,        1'b0, 1'b1, 32'd2, 32'd4, 0};
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_miss($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of WAIT_LINE abandons the request.
    @(negedge clk);
    miss_label = 27'h40;
    miss_req   = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst      = 1'b1;
    miss_req = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (miss_ack) ack_seen = 1'b1;
    end
    chk("no_ack_after_rst", 256'(ack_seen), 256'(1'b0));

    // A fresh request after reset is served normally.
    v = '{1'b0, 27'h0, 27'h50, 1'b0, 1'b0, 32'd0, 32'd1, 0};
    do_miss("post_rst", v);

    // Hit counter saturation
    @(negedge clk);
    force dut.hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt;
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 27'h60, 27'h60, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 2};
      do_miss($sformatf("sat%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
